// File: rtl/inst_loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
// Optional feature macro: INST_LOADER_CKSUM_EN (adds the trailing checksum byte
// check and the CKSUM / ERR states).
package inst_loader_pkg;

    localparam int INST_ADDR_W = 12;
    localparam int INST_W      = 9;
    localparam int CKSUM_W     = 8;

    typedef enum logic [2:0] {
        ST_LEN_LO = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_INS_LO = 3'd2,
        ST_INS_HI = 3'd3,
        ST_RUN    = 3'd4
`ifdef INST_LOADER_CKSUM_EN
        ,
        ST_CKSUM  = 3'd5,
        ST_ERR    = 3'd6
`endif
    } loader_state_t;

endpackage

// File: rtl/inst_loader.sv
// Program loader: takes a host byte stream (2-byte length header, then 2 bytes
// per instruction), packs byte pairs into instruction words and writes them to
// sequential instruction-memory addresses while holding the processor in init.
// Optional feature macro: INST_LOADER_CKSUM_EN (trailing XOR checksum byte,
// Error output, sticky ERR state left only by reset).
module inst_loader #(
    parameter int ADDR_W = inst_loader_pkg::INST_ADDR_W,
    parameter int INST_W = inst_loader_pkg::INST_W
) (
    input  logic              CLK,
    input  logic              Init_n,
    input  logic [7:0]        In_data,
    input  logic              In_valid,
    output logic              In_ready,
    input  logic              Halt,
    output logic              Wr_en,
    output logic [ADDR_W-1:0] Wr_addr,
    output logic [INST_W-1:0] Wr_data,
    output logic              Start,
`ifdef INST_LOADER_CKSUM_EN
    output logic              Error,
`endif
    output logic              Done
);

    import inst_loader_pkg::*;

    // Where the FSM goes once the final word (or an empty header) is taken.
`ifdef INST_LOADER_CKSUM_EN
    localparam loader_state_t ST_LOADED = ST_CKSUM;
`else
    localparam loader_state_t ST_LOADED = ST_RUN;
`endif

    loader_state_t     state_q, state_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [7:0]        lo_q, lo_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [INST_W-1:0] wr_data_q, wr_data_d;
    logic              start_q, start_d;
    logic              done_q, done_d;
    logic              in_ready_q, in_ready_d;
    logic              accept;
`ifdef INST_LOADER_CKSUM_EN
    logic [CKSUM_W-1:0] cksum_q, cksum_d;
    logic               error_q, error_d;
`endif

    // A byte moves only when the host offers it and the registered ready is high.
    assign accept = In_valid && in_ready_q;

    // Next-state, header/word assembly and write-strobe generation.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        lo_d      = lo_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            ST_LEN_LO: begin
                if (accept) begin
                    len_d[7:0] = In_data;
                    state_d    = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (accept) begin
                    len_d[ADDR_W-1:8] = In_data[ADDR_W-9:0];
                    cnt_d             = '0;
                    state_d           = (len_d == '0) ? ST_LOADED : ST_INS_LO;
                end
            end
            ST_INS_LO: begin
                if (accept) begin
                    lo_d    = In_data;
                    state_d = ST_INS_HI;
                end
            end
            ST_INS_HI: begin
                if (accept) begin
                    wr_data_d = {In_data[INST_W-9:0], lo_q};
                    wr_addr_d = cnt_q;
                    wr_en_d   = 1'b1;
                    cnt_d     = cnt_q + ADDR_W'(1);
                    state_d   = (cnt_d == len_q) ? ST_LOADED : ST_INS_LO;
                end
            end
            ST_RUN: begin
                if (Halt) begin
                    state_d = ST_LEN_LO;
                end
            end
`ifdef INST_LOADER_CKSUM_EN
            ST_CKSUM: begin
                if (accept) begin
                    state_d = (In_data == cksum_q) ? ST_RUN : ST_ERR;
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
`endif
            default: begin
                state_d = ST_LEN_LO;
            end
        endcase
    end

    // Start is released one edge after RUN is entered, so the last write (or an
    // empty header) settles first; a Halt in RUN re-arms on the same edge.
    always_comb begin
        start_d    = !((state_q == ST_RUN) && (state_d == ST_RUN));
        done_d     = !start_d;
        in_ready_d = (state_d != ST_RUN);
`ifdef INST_LOADER_CKSUM_EN
        if (state_d == ST_ERR) begin
            in_ready_d = 1'b0;
        end
`endif
    end

`ifdef INST_LOADER_CKSUM_EN
    // Running XOR of every stream byte, restarted by the first header byte.
    always_comb begin
        cksum_d = cksum_q;
        error_d = (state_d == ST_ERR);
        if (accept) begin
            case (state_q)
                ST_LEN_LO:                       cksum_d = In_data;
                ST_LEN_HI, ST_INS_LO, ST_INS_HI: cksum_d = cksum_q ^ In_data;
                default:                         cksum_d = cksum_q;
            endcase
        end
    end

    // Checksum accumulator and sticky error flag.
    always_ff @(posedge CLK or negedge Init_n) begin
        if (!Init_n) begin
            cksum_q <= '0;
            error_q <= 1'b0;
        end else begin
            cksum_q <= cksum_d;
            error_q <= error_d;
        end
    end

    assign Error = error_q;
`endif

    // Main loader registers; every output comes straight from a flop.
    always_ff @(posedge CLK or negedge Init_n) begin
        if (!Init_n) begin
            state_q    <= ST_LEN_LO;
            len_q      <= '0;
            cnt_q      <= '0;
            lo_q       <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            start_q    <= 1'b1;
            done_q     <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            lo_q       <= lo_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            start_q    <= start_d;
            done_q     <= done_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign In_ready = in_ready_q;
    assign Wr_en    = wr_en_q;
    assign Wr_addr  = wr_addr_q;
    assign Wr_data  = wr_data_q;
    assign Start    = start_q;
    assign Done     = done_q;

endmodule

// File: tb/tb_inst_loader.sv
// Testbench for inst_loader: a byte-index model of the program stream predicts
// every output on every cycle; directed streams pin the model with literals.
// Optional feature macro: INST_LOADER_CKSUM_EN (appends checksum bytes, checks Error).
module tb_inst_loader;

    localparam int ADDR_W = 12;
    localparam int INST_W = 9;

    logic              clk = 1'b0;
    logic              init_n = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              halt = 1'b0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [INST_W-1:0] wr_data;
    logic              start;
    logic              done;
`ifdef INST_LOADER_CKSUM_EN
    logic              error;
`endif

    inst_loader #(.ADDR_W(ADDR_W), .INST_W(INST_W)) dut (
        .CLK      (clk),
        .Init_n   (init_n),
        .In_data  (in_data),
        .In_valid (in_valid),
        .In_ready (in_ready),
        .Halt     (halt),
        .Wr_en    (wr_en),
        .Wr_addr  (wr_addr),
        .Wr_data  (wr_data),
        .Start    (start),
`ifdef INST_LOADER_CKSUM_EN
        .Error    (error),
`endif
        .Done     (done)
    );

    // 10-time-unit clock.
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef enum {M_LOAD, M_CKSUM, M_PEND, M_RUN, M_ERR} m_mode_t;

    m_mode_t m_mode = M_LOAD;
    int      m_idx = 0;
    int      m_len = 0;
    int      m_lo = 0;
    int      m_cks = 0;
    int      m_last_addr = 0;
    int      m_last_data = 0;
    bit      m_wr = 1'b0;

    int         log_addr[$];
    int         log_data[$];
    logic [7:0] stream[$];
    int         exp3_data[3] = '{'h155, 'h0AA, 'h13C};

    function void check_output(string name, int actual, int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    endfunction

    function void model_reset();
        m_mode = M_LOAD;
        m_idx = 0;
        m_len = 0;
        m_lo = 0;
        m_cks = 0;
        m_last_addr = 0;
        m_last_data = 0;
        m_wr = 1'b0;
    endfunction

    function void model_loaded();
`ifdef INST_LOADER_CKSUM_EN
        m_mode = M_CKSUM;
`else
        m_mode = M_PEND;
`endif
    endfunction

    // Interpret one accepted byte purely by its position in the program stream.
    function void model_accept(int b);
        int k;
        if (m_mode == M_CKSUM) begin
            m_mode = (b == m_cks) ? M_PEND : M_ERR;
            return;
        end
        m_cks = (m_idx == 0) ? b : (m_cks ^ b);
        if (m_idx == 0) begin
            m_lo = b;
        end else if (m_idx == 1) begin
            m_len = m_lo + 256 * (b % (1 << (ADDR_W - 8)));
            if (m_len == 0) model_loaded();
        end else begin
            k = m_idx - 2;
            if (k % 2 == 0) begin
                m_lo = b;
            end else begin
                m_wr = 1'b1;
                m_last_addr = k / 2;
                m_last_data = m_lo + 256 * (b % (1 << (INST_W - 8)));
                if (k / 2 + 1 == m_len) model_loaded();
            end
        end
        m_idx++;
    endfunction

    // Compare every output against the model mid-cycle, then advance the model
    // with the inputs that the next rising edge will sample.
    always @(negedge clk) begin
        if (!init_n) model_reset();
        check_output("in_ready", int'(in_ready), int'(m_mode == M_LOAD || m_mode == M_CKSUM));
        check_output("start", int'(start), int'(m_mode != M_RUN));
        check_output("done", int'(done), int'(m_mode == M_RUN));
        check_output("wr_en", int'(wr_en), int'(m_wr));
        check_output("wr_addr", int'(wr_addr), m_last_addr);
        check_output("wr_data", int'(wr_data), m_last_data);
`ifdef INST_LOADER_CKSUM_EN
        check_output("error", int'(error), int'(m_mode == M_ERR));
`endif
        if (wr_en) begin
            log_addr.push_back(int'(wr_addr));
            log_data.push_back(int'(wr_data));
        end
        if (init_n) begin
            m_wr = 1'b0;
            case (m_mode)
                M_PEND: begin
                    if (halt) begin
                        m_mode = M_LOAD;
                        m_idx = 0;
                    end else begin
                        m_mode = M_RUN;
                    end
                end
                M_RUN: begin
                    if (halt) begin
                        m_mode = M_LOAD;
                        m_idx = 0;
                    end
                end
                M_LOAD, M_CKSUM: begin
                    if (in_valid) model_accept(int'(in_data));
                end
                default: ;
            endcase
        end
    end

    // Offer one byte after an optional idle gap and hold it until it is taken.
    task apply_stimulus(input logic [7:0] b, input int gap, input bit rand_halt);
        int  tries;
        bit  rdy;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            if (rand_halt) halt = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        halt     = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        tries    = 0;
        rdy      = 1'b0;
        while (!rdy && tries < 20) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            tries++;
        end
        in_valid = 1'b0;
        if (!rdy) check_output("handshake_timeout", 0, 1);
    endtask

    task send_stream(input int min_gap, input int max_gap, input bit rand_halt);
        foreach (stream[i]) apply_stimulus(stream[i], $urandom_range(min_gap, max_gap), rand_halt);
    endtask

    // Append the XOR of the stream when the checksum feature is built in.
    task add_cksum();
`ifdef INST_LOADER_CKSUM_EN
        logic [7:0] x;
        x = 8'h00;
        foreach (stream[i]) x = x ^ stream[i];
        stream.push_back(x);
`endif
    endtask

    task wait_done(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_output("done_timeout", int'(done), 1);
    endtask

    task do_halt();
        halt = 1'b1;
        @(posedge clk);
        #1;
        halt = 1'b0;
        check_output("rearm_start", int'(start), 1);
        check_output("rearm_done", int'(done), 0);
        check_output("rearm_in_ready", int'(in_ready), 1);
    endtask

    task do_reset();
        in_valid = 1'b0;
        init_n   = 1'b0;
        #1;
        check_output("rst_start", int'(start), 1);
        check_output("rst_done", int'(done), 0);
        check_output("rst_wr_en", int'(wr_en), 0);
        check_output("rst_wr_addr", int'(wr_addr), 0);
        check_output("rst_wr_data", int'(wr_data), 0);
        check_output("rst_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        init_n = 1'b1;
    endtask

    task check_log3();
        check_output("log_size", log_addr.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check_output($sformatf("log_addr%0d", i), (log_addr.size() > i) ? log_addr[i] : -1, i);
            check_output($sformatf("log_data%0d", i), (log_data.size() > i) ? log_data[i] : -1, exp3_data[i]);
        end
    endtask

    task load_three_word();
        stream = '{8'h03, 8'h00, 8'h55, 8'h01, 8'hAA, 8'h00, 8'h3C, 8'h01};
        add_cksum();
    endtask

    // Safety net so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int len;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_output("init_start", int'(start), 1);
        check_output("init_in_ready", int'(in_ready), 1);
        check_output("init_wr_en", int'(wr_en), 0);
        init_n = 1'b1;

        $display("[TB] three-word load at full rate");
        load_three_word();
        log_addr.delete();
        log_data.delete();
        send_stream(0, 0, 1'b0);
`ifndef INST_LOADER_CKSUM_EN
        check_output("last_wr_en", int'(wr_en), 1);
        check_output("last_start_held", int'(start), 1);
        @(posedge clk);
        #1;
        check_output("after_wr_en", int'(wr_en), 0);
        check_output("after_start", int'(start), 0);
`endif
        wait_done(20);
        check_log3();
        do_halt();

        $display("[TB] zero-length program");
        stream = '{8'h00, 8'h00};
        add_cksum();
        log_addr.delete();
        log_data.delete();
        send_stream(0, 0, 1'b0);
        check_output("zero_start_held", int'(start), 1);
        check_output("zero_done_low", int'(done), 0);
        @(posedge clk);
        #1;
        check_output("zero_start_fall", int'(start), 0);
        check_output("zero_done", int'(done), 1);
        check_output("zero_no_writes", log_addr.size(), 0);
        do_halt();

        $display("[TB] alternate-cycle valid");
        load_three_word();
        log_addr.delete();
        log_data.delete();
        send_stream(1, 1, 1'b0);
        wait_done(40);
        check_log3();
        do_halt();

        $display("[TB] random gaps");
        load_three_word();
        log_addr.delete();
        log_data.delete();
        send_stream(0, 3, 1'b1);
        wait_done(40);
        check_log3();
        do_halt();

        $display("[TB] reload after halt");
        stream = '{8'h01, 8'h00, 8'h07, 8'h00};
        add_cksum();
        log_addr.delete();
        log_data.delete();
        send_stream(0, 0, 1'b0);
        wait_done(20);
        check_output("reload_count", log_addr.size(), 1);
        check_output("reload_addr", (log_addr.size() > 0) ? log_addr[0] : -1, 0);
        check_output("reload_data", (log_data.size() > 0) ? log_data[0] : -1, 'h007);
        do_halt();

        $display("[TB] reset mid-load");
        load_three_word();
        stream = stream[0:4];
        send_stream(0, 0, 1'b0);
        do_reset();
        load_three_word();
        log_addr.delete();
        log_data.delete();
        send_stream(0, 0, 1'b0);
        wait_done(20);
        check_log3();

        $display("[TB] random programs");
        for (int p = 0; p < 20; p++) begin
            do_halt();
            len = $urandom_range(1, 8);
            stream.delete();
            stream.push_back(8'(len));
            stream.push_back(8'($urandom_range(0, 15) << 4));
            for (int w = 0; w < 2 * len; w++) stream.push_back(8'($urandom));
            add_cksum();
            log_addr.delete();
            log_data.delete();
            send_stream(0, 3, 1'b1);
            wait_done(200);
            check_output("rand_count", log_addr.size(), len);
        end
        do_halt();

`ifdef INST_LOADER_CKSUM_EN
        $display("[TB] checksum good");
        stream = '{8'h01, 8'h00, 8'h07, 8'h00, 8'h06};
        send_stream(0, 0, 1'b0);
        wait_done(20);
        check_output("cks_good_error", int'(error), 0);
        do_halt();

        $display("[TB] checksum bad");
        stream = '{8'h01, 8'h00, 8'h07, 8'h00, 8'h05};
        send_stream(0, 0, 1'b0);
        repeat (4) begin
            check_output("cks_bad_error", int'(error), 1);
            check_output("cks_bad_start", int'(start), 1);
            check_output("cks_bad_ready", int'(in_ready), 0);
            halt = 1'b1;
            @(posedge clk);
            #1;
        end
        halt = 1'b0;
        do_reset();
        check_output("cks_cleared", int'(error), 0);
`endif

        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/inst_loader.md
# inst_loader

Host-facing program loader that writes the processor's instruction memory, the writer for the instruction fetch path. It accepts a byte stream from a host over a valid/ready handshake. The stream is a 2-byte length header followed by 2 bytes per instruction. The loader packs each byte pair into one instruction word and writes it to sequential addresses. While loading it holds the processor in init through `Start`, and releases `Start` once the last word is written. After the processor halts, it re-arms for the next program.

## Interface
- `ADDR_W`, default 12: instruction address width, matches the PC.
- `INST_W`, default 9: instruction width. Legal range 9..16. The high byte carries bits `[INST_W-1:8]`.
- `CLK`, in, 1: clock; all state changes on posedge.
- `Init_n`, in, 1: reset, asynchronous, active-low.
- `In_data`, in, 8: host byte.
- `In_valid`, in, 1: host byte valid.
- `In_ready`, out, 1: loader can accept a byte. A byte transfers on a posedge with `In_valid && In_ready`.
- `Halt`, in, 1: processor halt flag.
- `Wr_en`, out, 1: instruction memory write strobe, one cycle per word.
- `Wr_addr`, out, `ADDR_W`: write address.
- `Wr_data`, out, `INST_W`: write data.
- `Start`, out, 1: processor init, level. 1 holds the processor.
- `Done`, out, 1: program loaded and running.
- `Error`, out, 1: checksum failure; only exists with the checksum macro defined.

## Operation
- **States:** `LEN_LO`, `LEN_HI`, `INS_LO`, `INS_HI`, `CKSUM` (macro only), `RUN`, `ERR` (macro only).
- **Reset values:**
  - State `LEN_LO`; `Start`=1; `In_ready`=1.
  - `Done`=0, `Error`=0, `Wr_en`=0, `Wr_addr`=0, `Wr_data`=0.
  - Length and word counter = 0.
- **`LEN_LO`:** the accepted byte becomes `len[7:0]`. Next state `LEN_HI`.
- **`LEN_HI`:** the accepted byte's bits `[ADDR_W-9:0]` become `len[ADDR_W-1:8]`; upper bits are ignored. Word counter clears.
  - If `len` = 0, go to `RUN` (or `CKSUM`).
  - Otherwise go to `INS_LO`.
- **`INS_LO`:** latch the low byte. Next state `INS_HI`.
- **`INS_HI`:** on accept, register `Wr_data` = {`hi[INST_W-9:0]`, lo}, `Wr_addr` = counter, `Wr_en` = 1. Unused high-byte bits are ignored.
  - Counter increments.
  - If the counter reaches `len`, go to `RUN` (or `CKSUM`); otherwise go to `INS_LO`.
- **`In_ready`:** 1 in `LEN_LO`, `LEN_HI`, `INS_LO`, `INS_HI` and `CKSUM`; 0 in `RUN` and `ERR`. It is not a function of `In_valid`.
- **`RUN`:** `Start`=0, `Done`=1. `Halt`=1 sampled in `RUN` returns to `LEN_LO`, with `Start`=1 and `Done`=0 on that same edge.
- **`Halt` outside `RUN`:** ignored.
- **Reset mid-load:** aborts immediately. Words already written stay in memory; the counter restarts at 0.
- **Gaps:** idle cycles between bytes are legal anywhere.

## Timing
- **Write latency:** high byte accepted at edge k → `Wr_en`=1 for the cycle after edge k, deasserts at edge k+1.
- **`Start` release:** `Start` falls at edge k+1, coincident with `Wr_en` dropping, so the final write lands before the processor leaves init.
- **Zero length:** `Start` falls one edge after the `LEN_HI` accept. No `Wr_en` pulse.
- **Throughput:** one byte per cycle; one word every 2 cycles at full rate.
- **Registered outputs:** all outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- **`INST_LOADER_CKSUM_EN` defined:**
  - After the last word, state `CKSUM` accepts one byte.
  - A match against the XOR of all preceding bytes (header included) goes to `RUN`.
  - A mismatch goes to `ERR`: `Error`=1, `Start` held at 1, `In_ready`=0.
  - `ERR` is left only by reset.
- **Undefined:** no `CKSUM` or `ERR` state, no `Error` port. The final word goes straight to `RUN`.

## Structure
- **`inst_loader_pkg`:** state enum `loader_state_t`, default widths `INST_ADDR_W`=12 and `INST_W`=9, and checksum byte width.
- **Sub-modules:** none. This is a single-FSM module; the byte packing is a few registers and needs no sub-module.
- **Integration:** the top level drives the processor's `start` from `Start` and the instruction memory write port from `Wr_*`.

## Test plan
- **Three-word load:** bytes 03 00 55 01 AA 00 3C 01 at full rate → three `Wr_en` pulses: addr0=0x155, addr1=0x0AA, addr2=0x13C. `Start` falls with the last pulse's deassert; `Done`=1.
- **Zero length:** bytes 00 00 → no `Wr_en`; `Start` 1→0 one edge after the second accept.
- **Valid gaps:** same stream as the three-word load with `In_valid` low on alternate cycles and random 0-3 cycle gaps → identical write sequence; no byte dropped or duplicated.
- **Halt re-arm:** `Halt`=1 in `RUN` → `Start`=1, `Done`=0, `In_ready`=1. Then reload 01 00 07 00 → addr0=0x007 written, `Start` released.
- **Reset mid-load:** `Init_n` pulsed low after byte 5 of the three-word stream → all outputs at reset values immediately. A full restream then writes from addr0.
- **Checksum (with `INST_LOADER_CKSUM_EN`):**
  - Stream 01 00 07 00 then 06 → `RUN`.
  - Stream 01 00 07 00 then 05 → `Error`=1, `Start`=1, `In_ready`=0 until reset.
